fsm_rx: RTL and testbench

FSM_RX -- requirements
Module: fsm_rx

---
 rtl/fsm_rx_pkg.sv | 30 +++
 rtl/rx_data_sampling.sv | 39 +++
 rtl/fsm_rx.sv | 146 ++++++++++++++
 tb/tb_fsm_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_rx_pkg.sv
// Shared types and constants for the UART receive FSM: state encoding,
// legal oversampling ratios and the small helper functions used by the datapath.
package fsm_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Anything other than 16 or 32 falls back to the slowest legal ratio.
  function automatic logic [5:0] legal_prescale(input logic [5:0] raw);
    case (raw)
      PRESCALE_16: legal_prescale = PRESCALE_16;
      PRESCALE_32: legal_prescale = PRESCALE_32;
      default:     legal_prescale = PRESCALE_8;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_data_sampling.sv
// Three-point majority sampler: captures the line around mid-bit and presents
// the voted bit value from edge_cnt = half+2 until the next vote.
module rx_data_sampling
  import fsm_rx_pkg::*;
(
  input  logic       CLK_RX,
  input  logic       RST_RX,
  input  logic       rx_in,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] half_cnt,
  output logic       sampled_bit
);

  logic sample_a_r;
  logic sample_b_r;
  logic sampled_bit_r;

  // Capture the first two samples, then vote with the third as it arrives.
  always_ff @(posedge CLK_RX or posedge RST_RX) begin
    if (RST_RX) begin
      sample_a_r    <= 1'b1;
      sample_b_r    <= 1'b1;
      sampled_bit_r <= 1'b1;
    end else begin
      if (edge_cnt == (half_cnt - 6'd1)) begin
        sample_a_r <= rx_in;
      end
      if (edge_cnt == half_cnt) begin
        sample_b_r <= rx_in;
      end
      if (edge_cnt == (half_cnt + 6'd1)) begin
        sampled_bit_r <= majority3(sample_a_r, sample_b_r, rx_in);
      end
    end
  end

  assign sampled_bit = sampled_bit_r;

endmodule

// File: rtl/fsm_rx.sv
// UART receive FSM with oversampled majority-vote bit recovery and parity/stop checks.
// Define RX_GLITCH_FILTER_EN to abandon start bits whose mid-bit vote reads high.
module fsm_rx
  import fsm_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_RX,
  input  logic                  RST_RX,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_r;
  logic [5:0]            edge_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [5:0]            prescale_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;

  logic [5:0] half_s;
  logic       last_edge_s;
  logic       sampled_bit_s;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    expected_parity = (^d) ^ odd;
  endfunction

  assign half_s      = {1'b0, prescale_r[5:1]};
  assign last_edge_s = (edge_cnt_r == (prescale_r - 6'd1));

  rx_data_sampling u_sampler (
    .CLK_RX      (CLK_RX),
    .RST_RX      (RST_RX),
    .rx_in       (RX_IN),
    .edge_cnt    (edge_cnt_r),
    .half_cnt    (half_s),
    .sampled_bit (sampled_bit_s)
  );

`ifdef RX_GLITCH_FILTER_EN
  logic glitch_s;
  assign glitch_s = (edge_cnt_r == (half_s + 6'd2)) && sampled_bit_s;
`endif

  // Frame sequencing, bit counters, deserialiser and error/valid outputs.
  always_ff @(posedge CLK_RX or posedge RST_RX) begin
    if (RST_RX) begin
      state_r      <= IDLE;
      edge_cnt_r   <= 6'd0;
      bit_cnt_r    <= {BIT_CNT_W{1'b0}};
      prescale_r   <= PRESCALE_8;
      par_en_r     <= 1'b0;
      par_typ_r    <= 1'b0;
      data_r       <= {DATA_WIDTH{1'b0}};
      p_data_r     <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      if (state_r == IDLE) begin
        edge_cnt_r <= 6'd0;
      end else begin
        edge_cnt_r <= last_edge_s ? 6'd0 : (edge_cnt_r + 6'd1);
      end

      case (state_r)
        IDLE: begin
          // Line configuration is frozen for the whole frame from here on.
          if (!RX_IN) begin
            state_r    <= START;
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            par_err_r  <= 1'b0;
            stp_err_r  <= 1'b0;
            prescale_r <= legal_prescale(PRESCALE);
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
          end
        end
        START: begin
`ifdef RX_GLITCH_FILTER_EN
          if (glitch_s) begin
            state_r    <= IDLE;
            edge_cnt_r <= 6'd0;
          end else if (last_edge_s) begin
            state_r <= DATA;
          end
`else
          if (last_edge_s) begin
            state_r <= DATA;
          end
`endif
        end
        DATA: begin
          if (last_edge_s) begin
            data_r    <= {sampled_bit_s, data_r[DATA_WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= par_en_r ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (last_edge_s) begin
            par_err_r <= (sampled_bit_s != expected_parity(data_r, par_typ_r));
            state_r   <= STOP;
          end
        end
        STOP: begin
          if (last_edge_s) begin
            stp_err_r <= !sampled_bit_s;
            if (sampled_bit_s && !par_err_r) begin
              p_data_r     <= data_r;
              data_valid_r <= 1'b1;
            end
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign P_DATA     = p_data_r;
  assign DATA_VALID = data_valid_r;
  assign PAR_ERR    = par_err_r;
  assign STP_ERR    = stp_err_r;

endmodule

// File: tb/tb_fsm_rx.sv
// Randomised self-checking bench for fsm_rx: a serial-line driver plus a
// frame-level scoreboard predicting the cycle, data and flags of every frame end.
module tb_fsm_rx;

  localparam int DW = 8;

  logic          CLK_RX = 1'b0;
  logic          RST_RX;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [5:0]    PRESCALE;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  typedef struct {
    int         cyc;
    logic       dv;
    logic [7:0] pd;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic [5:0] p_tab [8] = '{6'd8, 6'd16, 6'd32, 6'd0, 6'd5, 6'd12, 6'd40, 6'd63};

  fsm_rx #(.DATA_WIDTH(DW)) dut (
    .CLK_RX     (CLK_RX),
    .RST_RX     (RST_RX),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK_RX = ~CLK_RX;

  always @(posedge CLK_RX) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Frame-end scoreboard: exact pulse cycle, data and flags; any other pulse is spurious.
  always @(negedge CLK_RX) begin
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      check_val("data_valid", DATA_VALID, exp_q[0].dv);
      check_val("p_data",     P_DATA,     exp_q[0].pd);
      check_val("par_err",    PAR_ERR,    exp_q[0].pe);
      check_val("stp_err",    STP_ERR,    exp_q[0].se);
      void'(exp_q.pop_front());
    end else if (DATA_VALID === 1'b1) begin
      check_val("dv_spurious", DATA_VALID, 1'b0);
    end
  end

  // One bit period of P clocks; optionally flip the middle of the three vote samples.
  task automatic drive_bit(input logic v, input int p, input bit glitch, output int first_cyc);
    first_cyc = 0;
    for (int k = 0; k < p; k++) begin
      @(negedge CLK_RX);
      if (k == 0) first_cyc = cyc;
      RX_IN = (glitch && k == p / 2 + 1) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [5:0] p_raw, input logic pe,
                            input logic pt, input bit bad_par, input bit bad_stop,
                            input int glitch_idx, input int gap);
    int   p;
    int   c;
    int   dummy;
    exp_t e;
    logic par_bit;
    p = (p_raw == 6'd16) ? 16 : (p_raw == 6'd32) ? 32 : 8;
    PRESCALE = p_raw;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    drive_bit(1'b0, p, 1'b0, c);
    // Detection happened on the edge after the first low drive; the pulse follows the last bit.
    e.cyc = c + 1 + (pe ? 11 : 10) * p;
    e.pe  = pe & bad_par;
    e.se  = bad_stop;
    e.dv  = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.pd  = last_good;
    exp_q.push_back(e);
    PRESCALE = 6'($urandom);
    PAR_EN   = 1'($urandom);
    PAR_TYP  = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p, glitch_idx == i, dummy);
    par_bit = (^d) ^ pt ^ bad_par;
    if (pe) drive_bit(par_bit, p, 1'b0, dummy);
    drive_bit(~bad_stop, p, 1'b0, dummy);
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK_RX);
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    int dummy;
    int c;
    exp_t e;
    RST_RX   = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    PRESCALE = 6'd8;
    repeat (3) @(negedge CLK_RX);
    check_val("rst_p_data",     P_DATA,     8'h00);
    check_val("rst_data_valid", DATA_VALID, 1'b0);
    check_val("rst_par_err",    PAR_ERR,    1'b0);
    check_val("rst_stp_err",    STP_ERR,    1'b0);
    RST_RX = 1'b0;
    repeat (3) @(negedge CLK_RX);

    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3);
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 3);
    send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);

    // Two-clock low pulse at PRESCALE=16 after an errored frame.
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    @(negedge CLK_RX);
    RX_IN = 1'b0;
    c = cyc;
    @(negedge CLK_RX);
    @(negedge CLK_RX);
    RX_IN = 1'b1;
`ifndef RX_GLITCH_FILTER_EN
    e.cyc = c + 1 + 10 * 16;
    e.dv  = 1'b1;
    e.pd  = 8'hFF;
    e.pe  = 1'b0;
    e.se  = 1'b0;
    last_good = 8'hFF;
    exp_q.push_back(e);
`endif
    repeat (10 * 16 + 4) @(negedge CLK_RX);
    check_val("glitch_par_err", PAR_ERR, 1'b0);
    check_val("glitch_stp_err", STP_ERR, 1'b0);

    // Back-to-back: the next start is driven in the single idle clock after STOP,
    // so the pulses are one frame (10*P) plus that idle clock apart.
    send_frame(8'h01, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1);
    send_frame(8'h80, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3);

    for (int n = 0; n < 24; n++) begin
      logic pe;
      int   gi;
      pe = 1'($urandom);
      gi = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7));
      send_frame(8'($urandom), p_tab[$urandom_range(0, 7)], pe, 1'($urandom),
                 pe && ($urandom_range(0, 4) == 0), $urandom_range(0, 5) == 0,
                 gi, int'($urandom_range(1, 4)));
    end

    send_frame(8'hC3, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 2);

    // Reset in the middle of the data bits at PRESCALE=32.
    PRESCALE = 6'd32;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 32, 1'b0, dummy);
    for (int i = 0; i < 3; i++) drive_bit(1'(i), 32, 1'b0, dummy);
    @(negedge CLK_RX);
    RST_RX = 1'b1;
    RX_IN  = 1'b1;
    #1;
    check_val("midrst_p_data",     P_DATA,     8'h00);
    check_val("midrst_data_valid", DATA_VALID, 1'b0);
    check_val("midrst_par_err",    PAR_ERR,    1'b0);
    check_val("midrst_stp_err",    STP_ERR,    1'b0);
    last_good = 8'h00;
    @(negedge CLK_RX);
    RST_RX = 1'b0;
    repeat (4) @(negedge CLK_RX);
    send_frame(8'h5A, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 4);

    repeat (4) @(negedge CLK_RX);
    check_val("pending_frames", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
